// File: rtl/shared_pkg.sv
// rtl/shared_pkg.sv - shared constants and operation encoding for the programmable-flag FIFO
package shared_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    // Classify a cycle from its accepted write/read qualifiers.
    function automatic fifo_op_e op_decode(input logic wr_acc, input logic rd_acc);
        return fifo_op_e'({rd_acc, wr_acc});
    endfunction

endpackage

// File: rtl/fifo_prog_mem.sv
// rtl/fifo_prog_mem.sv - dual-port register array, one write port and one asynchronous read port
module fifo_prog_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Deliberately unreset: contents are only meaningful behind the pointers.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_prog.sv
// rtl/fifo_prog.sv - synchronous FIFO with programmable flags; FIFO_PROG_FWFT_EN selects first-word-fall-through
module fifo_prog
    import shared_pkg::*;
#(
    parameter  int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic                  prog_full,
    output logic                  prog_empty,
    output logic [CNT_W-1:0]      count
);

    localparam int                AW       = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  AFULL_C  = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  AEMPTY_C = CNT_W'(1);
    localparam logic [AW-1:0]     LAST_PTR = AW'(FIFO_DEPTH - 1);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CNT_W-1:0]      cnt_q;
    logic                  wr_ok;
    logic                  rd_ok;
    fifo_op_e              op;
    logic [FIFO_WIDTH-1:0] mem_rd;

    // Depth need not be a power of two, so pointers wrap on an explicit compare.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign count       = cnt_q;
    assign full        = (cnt_q == DEPTH_C);
    assign empty       = (cnt_q == '0);
    assign almostfull  = (cnt_q == AFULL_C);
    assign almostempty = (cnt_q == AEMPTY_C);
    assign prog_full   = (cnt_q >= af_thresh);
    assign prog_empty  = (cnt_q <= ae_thresh);

    // A write into a full FIFO is allowed when a read frees the slot in the same cycle.
    always_comb begin
        rd_ok = rd_en && !empty;
        wr_ok = wr_en && (!full || rd_ok);
        op    = op_decode(wr_ok, rd_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_ok;
            overflow  <= wr_en && !wr_ok;
            underflow <= rd_en && !rd_ok;
            if (wr_ok) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            unique case (op)
                OP_WR:   cnt_q <= cnt_q + 1'b1;
                OP_RD:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    fifo_prog_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd)
    );

`ifdef FIFO_PROG_FWFT_EN
    // Head word is shown directly; the last shown word is held once the FIFO drains.
    logic [FIFO_WIDTH-1:0] hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (!empty) begin
            hold_q <= mem_rd;
        end
    end

    assign data_out = empty ? hold_q : mem_rd;
`else
    logic [FIFO_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else if (rd_ok) begin
            dout_q <= mem_rd;
        end
    end

    assign data_out = dout_q;
`endif

endmodule

// File: doc/fifo_prog.md
FIFO_PROG -- requirements
Module: fifo_prog

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16: data_in/data_out and storage word width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: number of storage words; legal range 2..1024, not required to be a power of two.
REQ-003 SHALL have localparam CNT_W = $clog2(FIFO_DEPTH+1): width of occupancy and threshold values.
REQ-004 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: data_in  input  FIFO_WIDTH  write data.
REQ-007 SHALL have port: wr_en  input  1  write request.
REQ-008 SHALL have port: rd_en  input  1  read request.
REQ-009 SHALL have port: af_thresh  input  CNT_W  programmable-full level.
REQ-010 SHALL have port: ae_thresh  input  CNT_W  programmable-empty level.
REQ-011 SHALL have port: data_out  output  FIFO_WIDTH  read data.
REQ-012 SHALL have port: wr_ack  output  1  registered; last-cycle write accepted.
REQ-013 SHALL have port: overflow  output  1  registered; last-cycle write rejected (full).
REQ-014 SHALL have port: underflow  output  1  registered; last-cycle read rejected (empty).
REQ-015 SHALL have port: full, empty, almostfull, almostempty  output  1 each  combinational from count.
REQ-016 SHALL have port: prog_full, prog_empty  output  1 each  combinational threshold flags.
REQ-017 SHALL have port: count  output  CNT_W  current occupancy, 0..FIFO_DEPTH.

Function
REQ-018 SHALL accept a write when wr_en=1 and (count<FIFO_DEPTH, or count==FIFO_DEPTH with an accepted read in the same cycle).
REQ-019 SHALL accept a read when rd_en=1 and count>0; on empty with simultaneous wr_en, write only is accepted, read flagged underflow.
REQ-020 SHALL update count: +1 write-only, -1 read-only, unchanged for both accepted or neither.
REQ-021 SHALL wrap wr_ptr/rd_ptr from FIFO_DEPTH-1 to 0 (explicit compare; no modulo-2^n assumption).
REQ-022 SHALL drive full=(count==FIFO_DEPTH), empty=(count==0), almostfull=(count==FIFO_DEPTH-1), almostempty=(count==1).
REQ-023 SHALL drive prog_full=(count>=af_thresh), prog_empty=(count<=ae_thresh); thresholds sampled combinationally, changes take effect immediately.
REQ-024 SHALL in standard mode present popped word on data_out one cycle after an accepted read; data_out holds otherwise.
REQ-025 SHALL set wr_ack/overflow/underflow for exactly the cycle after the request; overflow and wr_ack are mutually exclusive.
REQ-026 SHALL leave storage contents and pointers unchanged on rejected operations.

Reset
REQ-027 SHALL on rst=1 immediately clear wr_ptr, rd_ptr, count, data_out, wr_ack, overflow, underflow; empty=1, prog_empty=1 (ae_thresh>=0), full=0; storage array not reset.
REQ-028 SHALL on reset mid-operation discard all content; first accepted read after release returns first post-reset write.

Configuration
REQ-029 SHALL support macro FIFO_PROG_FWFT_EN: defined -> first-word-fall-through: data_out shows head word combinationally-from-registers whenever empty=0, rd_en acknowledges and advances with zero read latency; data_out undefined-but-stable (held) when empty.
REQ-030 SHALL without FIFO_PROG_FWFT_EN behave per REQ-024 (one-cycle read latency); all flags, count and handshake timing identical in both modes.

Structure
REQ-031 SHALL place in shared_pkg: default width/depth constants and an enum fifo_op_e {OP_IDLE, OP_WR, OP_RD, OP_RW} used by RTL and bench scoreboard.
REQ-032 SHALL implement storage as sub-module fifo_prog_mem (dual-port register array, one write port, one read port); control, pointers and flags stay in fifo_prog.

Verification
REQ-033 SHALL cover: reset, write 8 words 0x0001..0x0008 (DEPTH=8) -> full=1 after 8th, almostfull=1 after 7th, count=8; 9th write -> overflow=1, wr_ack=0, content intact.
REQ-034 SHALL cover: read 9 from full -> data_out 0x0001..0x0008 in order, 9th read -> underflow=1, empty=1, count=0.
REQ-035 SHALL cover: full with wr_en=rd_en=1 data_in=0xAAAA -> both accepted, count stays 8, 0xAAAA read last; empty with both -> write only, underflow=1, count=1.
REQ-036 SHALL cover: af_thresh=5, ae_thresh=2, fill 0->8 -> prog_empty=1 for count 0..2, prog_full=1 for count 5..8; change af_thresh to 7 at count 6 -> prog_full drops same cycle.
REQ-037 SHALL cover: DEPTH=5, 20 interleaved write/read cycles crossing pointer wrap -> scoreboard order matches, no flag mismatch.
REQ-038 SHALL cover: rst asserted mid-burst at count=4 (async, between edges) -> count=0, empty=1 immediately; in FWFT build first post-reset write visible on data_out next cycle.
